msg_loader: RTL and testbench
=============================

# msg_loader

Message loader for the scrolling display path: accepts ASCII characters over a valid/ready byte stream and assembles them into a double-buffered message store that the scrolling logic reads. A carriage return atomically commits the assembled message, so the scroller never sees a half-written message. It is the writer side of the message that the scroller and converter consume.

## Interface
- MSG_LEN, 11, maximum message length in characters
- CHAR_WIDTH, 8, character width in bits
- PAD_CHAR, 8'h20, value returned for unused or out-of-range positions
- clk  input  1  system clock, same domain as the scroller
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data holds a character
- in_data  input  CHAR_WIDTH  ASCII character
- in_ready  output  1  loader accepts; transfer when in_valid && in_ready
- rd_addr  input  $clog2(MSG_LEN)  scroller read position
- rd_data  output  CHAR_WIDTH  character at rd_addr in the active bank
- msg_len  output  $clog2(MSG_LEN+1)  length of the active message
- msg_update  output  1  one-cycle pulse when a new message becomes active
- overflow  output  1  sticky flag: last message attempt exceeded MSG_LEN

## Operation
- Two banks of MSG_LEN characters: active (read) and shadow (write). Writes go only to shadow.
- FSM states: IDLE, FILL, DISCARD, COMMIT.
- IDLE: printable char (not CR 8'h0D, not ESC 8'h1B) -> written to shadow[0], count=1, go FILL. CR or ESC -> ignored, stay IDLE.
- FILL: printable char with count<MSG_LEN -> shadow[count], count+1. Printable char with count==MSG_LEN -> go DISCARD, char dropped. CR -> go COMMIT. ESC -> count=0, go IDLE, no commit.
- DISCARD: all chars dropped. CR -> overflow=1, count=0, go IDLE, no commit. ESC -> count=0, go IDLE, overflow unchanged.
- COMMIT (one cycle): active bank toggles, msg_len=count, overflow=0, count=0, go IDLE.
- CR with count 0 (in IDLE) never commits; the active message is unchanged.
- rd_data combinational: PAD_CHAR if rd_addr>=msg_len (covers rd_addr>=MSG_LEN), else active[rd_addr].
- Shadow bank contents are not cleared. Positions >= count are masked by msg_len.

## Timing
- Reset values: in_ready=1, msg_len=0, msg_update=0, overflow=0, rd_data=PAD_CHAR for any rd_addr, state IDLE, active bank 0.
- in_ready=1 in IDLE, FILL and DISCARD. in_ready=0 only in COMMIT.
- Commit sequence:
  - CR accepted in cycle N.
  - Cycle N+1: COMMIT, in_ready=0.
  - From cycle N+2: new bank active, msg_len updated, msg_update=1 for cycle N+2 only.
- Back-to-back characters are accepted at one per cycle, except during the COMMIT bubble.
- rd_data follows rd_addr in the same cycle, with no registered latency. The bank swap changes rd_data for an unchanged rd_addr at cycle N+2.
- rst_n asserted mid-fill or mid-commit:
  - Immediately returns all outputs to their reset values and discards the partial message.
  - Bank contents need not be reset; they are masked by msg_len=0.

## Configuration
- MSG_LOADER_UPCASE_EN defined:
  - Characters 8'h61–8'h7A are stored as the value minus 8'h20, so lowercase becomes uppercase for the 7-segment converter.
  - This applies in IDLE and FILL; CR/ESC detection is unaffected.
- Undefined: characters are stored unmodified.

## Structure
- Package msg_pkg:
  - CHAR_CR=8'h0D, CHAR_ESC=8'h1B, default PAD_CHAR.
  - State enum: IDLE, FILL, DISCARD, COMMIT.
- Sub-module msg_bank, instantiated twice:
  - MSG_LEN×CHAR_WIDTH register file.
  - One synchronous write port (we, waddr, wdata) and one combinational read port.
  - No reset.
- msg_loader holds the FSM, count, active-bank select, msg_len, flags and the output mux.

## Test plan
- Reset, rd_addr 0..10 -> rd_data=8'h20 everywhere, msg_len=0, in_ready=1.
- Stream "HELLO",CR at one per cycle:
  - in_ready=0 exactly one cycle after CR, then msg_update pulse.
  - msg_len=5, rd_addr 0..4 -> "HELLO", rd_addr 5..10 -> 8'h20.
- With "HELLO" active, send "AB" then ESC -> no msg_update, msg_len stays 5, rd_data still "HELLO".
- Send 12 chars "ABCDEFGHIJKL",CR:
  - No commit, overflow=1, previous message unchanged.
  - Then "HI",CR -> msg_len=2, overflow=0.
- Lone CR in IDLE -> no msg_update, outputs unchanged.
- Assert rst_n low after "WOR" mid-fill -> all outputs at reset values.
  - Then "ok",CR -> rd_data "OK" with MSG_LOADER_UPCASE_EN, "ok" without.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared constants and FSM state type for the message loader.
package msg_pkg;

  localparam logic [7:0] CHAR_CR          = 8'h0D;
  localparam logic [7:0] CHAR_ESC         = 8'h1B;
  localparam logic [7:0] DEFAULT_PAD_CHAR = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DISCARD,
    COMMIT
  } state_e;

endpackage

// File: rtl/msg_loader_if.sv
// Valid/ready character stream feeding the message loader.
interface msg_loader_if #(
  parameter int unsigned CHAR_WIDTH = 8
);

  logic                  in_valid;
  logic [CHAR_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/msg_bank.sv
// MSG_LEN x CHAR_WIDTH register file: one synchronous write port, one combinational read port.
module msg_bank #(
  parameter int unsigned MSG_LEN    = 11,
  parameter int unsigned CHAR_WIDTH = 8,
  localparam int unsigned AW        = $clog2(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [CHAR_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [CHAR_WIDTH-1:0] rdata
);

  logic [CHAR_WIDTH-1:0] mem_q [MSG_LEN];
  logic                  waddr_ok;
  logic                  raddr_ok;

  always_comb begin
    waddr_ok = ({1'b0, waddr} < (AW+1)'(MSG_LEN));
    raddr_ok = ({1'b0, raddr} < (AW+1)'(MSG_LEN));
    rdata    = raddr_ok ? mem_q[raddr] : '0;
  end

  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/msg_loader.sv
// Double-buffered message loader: CR atomically swaps the assembled shadow bank in.
// Optional MSG_LOADER_UPCASE_EN stores lowercase letters as uppercase.
module msg_loader
  import msg_pkg::*;
#(
  parameter int unsigned          MSG_LEN    = 11,
  parameter int unsigned          CHAR_WIDTH = 8,
  parameter logic [CHAR_WIDTH-1:0] PAD_CHAR  = CHAR_WIDTH'(DEFAULT_PAD_CHAR),
  localparam int unsigned         AW         = $clog2(MSG_LEN),
  localparam int unsigned         LW         = $clog2(MSG_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  msg_loader_if.slave           in_if,
  input  logic [AW-1:0]         rd_addr,
  output logic [CHAR_WIDTH-1:0] rd_data,
  output logic [LW-1:0]         msg_len,
  output logic                  msg_update,
  output logic                  overflow
);

  state_e          state_q, state_d;
  logic [LW-1:0]   count_q, count_d;
  logic [LW-1:0]   msg_len_q, msg_len_d;
  logic            active_q, active_d;
  logic            overflow_q, overflow_d;
  logic            msg_update_q, msg_update_d;

  logic                  accept;
  logic                  is_cr;
  logic                  is_esc;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [CHAR_WIDTH-1:0] wr_data;
  logic [CHAR_WIDTH-1:0] rdata0, rdata1;

  always_comb begin
    in_if.in_ready = (state_q != COMMIT);
    accept  = in_if.in_valid && in_if.in_ready;
    is_cr   = (in_if.in_data == CHAR_WIDTH'(CHAR_CR));
    is_esc  = (in_if.in_data == CHAR_WIDTH'(CHAR_ESC));
    wr_data = in_if.in_data;
`ifdef MSG_LOADER_UPCASE_EN
    if (in_if.in_data >= CHAR_WIDTH'(8'h61) && in_if.in_data <= CHAR_WIDTH'(8'h7A)) begin
      wr_data = in_if.in_data - CHAR_WIDTH'(8'h20);
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    msg_len_d    = msg_len_q;
    active_d     = active_q;
    overflow_d   = overflow_q;
    msg_update_d = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = count_q[AW-1:0];

    case (state_q)
      IDLE: begin
        if (accept && !is_cr && !is_esc) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = LW'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          if (is_cr) begin
            state_d = COMMIT;
          end else if (is_esc) begin
            count_d = '0;
            state_d = IDLE;
          end else if (count_q < LW'(MSG_LEN)) begin
            wr_en   = 1'b1;
            count_d = count_q + LW'(1);
          end else begin
            state_d = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (accept) begin
          if (is_cr) begin
            overflow_d = 1'b1;
            count_d    = '0;
            state_d    = IDLE;
          end else if (is_esc) begin
            count_d = '0;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        active_d     = ~active_q;
        msg_len_d    = count_q;
        overflow_d   = 1'b0;
        count_d      = '0;
        msg_update_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      msg_len_q    <= '0;
      active_q     <= 1'b0;
      overflow_q   <= 1'b0;
      msg_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      msg_len_q    <= msg_len_d;
      active_q     <= active_d;
      overflow_q   <= overflow_d;
      msg_update_q <= msg_update_d;
    end
  end

  // The shadow bank is whichever one is not active.
  msg_bank #(.MSG_LEN(MSG_LEN), .CHAR_WIDTH(CHAR_WIDTH)) u_bank0 (
    .clk   (clk),
    .we    (wr_en && active_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  msg_bank #(.MSG_LEN(MSG_LEN), .CHAR_WIDTH(CHAR_WIDTH)) u_bank1 (
    .clk   (clk),
    .we    (wr_en && !active_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  always_comb begin
    msg_len    = msg_len_q;
    msg_update = msg_update_q;
    overflow   = overflow_q;
    if (LW'(rd_addr) >= msg_len_q) begin
      rd_data = PAD_CHAR;
    end else begin
      rd_data = active_q ? rdata1 : rdata0;
    end
  end

endmodule

// File: tb/tb_msg_loader.sv
// Scoreboard bench for msg_loader: commits queue their expected length, a monitor checks each msg_update.
module tb_msg_loader;

  localparam int unsigned MSG_LEN = 11;
  localparam int unsigned CW      = 8;
  localparam int unsigned AW      = $clog2(MSG_LEN);
  localparam int unsigned LW      = $clog2(MSG_LEN + 1);

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
  logic [LW-1:0] msg_len;
  logic          msg_update;
  logic          overflow;

  int checks;
  int errors;
  int updates_seen;
  int sb_len[$];

  msg_loader_if #(.CHAR_WIDTH(CW)) lif ();

  msg_loader #(.MSG_LEN(MSG_LEN), .CHAR_WIDTH(CW), .PAD_CHAR(8'h20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (lif.slave),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .msg_len    (msg_len),
    .msg_update (msg_update),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every msg_update pulse must match the next queued commit.
  always @(negedge clk) begin
    if (rst_n && msg_update) begin
      updates_seen++;
      if (sb_len.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got msg_len %0d required no update", msg_len);
      end else begin
        chk("update_msg_len", int'(msg_len), sb_len.pop_front());
        chk("update_overflow", int'(overflow), 0);
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int waited;
    waited = 0;
    lif.in_valid = 1'b1;
    lif.in_data  = c;
    while (!lif.in_ready && waited < 5) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!lif.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready 0 required 1");
    end
    @(posedge clk);
    #1;
    lif.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input string name, input string s);
    for (int i = 0; i < MSG_LEN; i++) begin
      rd_addr = AW'(i);
      #1;
      chk(name, int'(rd_data), (i < s.len()) ? int'(s[i]) : 32'h20);
    end
    rd_addr = '0;
  endtask

  // CR followed by the exact bubble/pulse timing check.
  task automatic commit_cr(input int exp_len);
    sb_len.push_back(exp_len);
    send(8'h0D);
    chk("bubble_ready", int'(lif.in_ready), 0);
    chk("bubble_update", int'(msg_update), 0);
    @(posedge clk);
    #1;
    chk("post_ready", int'(lif.in_ready), 1);
    chk("post_update", int'(msg_update), 1);
    chk("post_len", int'(msg_len), exp_len);
    @(posedge clk);
    #1;
    chk("pulse_end", int'(msg_update), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_len"}, int'(msg_len), 0);
    chk({tag, "_ready"}, int'(lif.in_ready), 1);
    chk({tag, "_update"}, int'(msg_update), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    scan({tag, "_rd"}, "");
  endtask

  initial begin
    string ok_exp;
`ifdef MSG_LOADER_UPCASE_EN
    ok_exp = "OK";
`else
    ok_exp = "ok";
`endif
    checks = 0;
    errors = 0;
    updates_seen = 0;
    rst_n = 1'b0;
    lif.in_valid = 1'b0;
    lif.in_data  = '0;
    rd_addr = '0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_str("HELLO");
    commit_cr(5);
    scan("hello_rd", "HELLO");

    send_str("AB");
    send(8'h1B);
    idle(3);
    chk("esc_len", int'(msg_len), 5);
    scan("esc_rd", "HELLO");

    send_str("ABCDEFGHIJKL");
    send(8'h0D);
    idle(3);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_len", int'(msg_len), 5);
    scan("ovf_rd", "HELLO");

    send_str("HI");
    commit_cr(2);
    chk("hi_ovf", int'(overflow), 0);
    scan("hi_rd", "HI");

    send(8'h0D);
    idle(3);
    chk("lone_cr_len", int'(msg_len), 2);
    chk("lone_cr_ovf", int'(overflow), 0);
    scan("lone_cr_rd", "HI");

    send_str("WOR");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midfill");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_str("ok");
    commit_cr(2);
    scan("ok_rd", ok_exp);

    idle(3);
    chk("sb_drained", sb_len.size(), 0);
    chk("update_count", updates_seen, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
